// File: rtl/morse_msg_sequencer_if.sv
// morse_msg_sequencer_if: letter push handshake, playback control and Morse line status; MORSE_LOOP_EN adds loop control
interface morse_msg_sequencer_if #(
  parameter int FIFO_DEPTH = 4
);
  logic [2:0] sym_in;
  logic sym_valid;
  logic sym_ready;
  logic start;
  logic abort;
  logic morse_out;
  logic busy;
  logic unit_tick;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
`ifdef MORSE_LOOP_EN
  logic loop;
  modport master (
    output sym_in, sym_valid, start, abort, loop,
    input sym_ready, morse_out, busy, unit_tick, fifo_count
  );
  modport slave (
    input sym_in, sym_valid, start, abort, loop,
    output sym_ready, morse_out, busy, unit_tick, fifo_count
  );
`else
  modport master (
    output sym_in, sym_valid, start, abort,
    input sym_ready, morse_out, busy, unit_tick, fifo_count
  );
  modport slave (
    input sym_in, sym_valid, start, abort,
    output sym_ready, morse_out, busy, unit_tick, fifo_count
  );
`endif
endinterface

// File: rtl/morse_msg_sequencer.sv
// morse_msg_sequencer: buffers letter codes S..Z and plays them back-to-back on one LED line; MORSE_LOOP_EN repeats the message
module morse_msg_sequencer #(
  parameter int TICK_DIV = 25000000,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_UNITS = 3
) (
  input logic clock,
  input logic reset,
  morse_msg_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam int GW = $clog2(GAP_UNITS + 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] GAP_INIT = GW'(GAP_UNITS);
  localparam logic [CW-1:0] DEPTH = CW'(FIFO_DEPTH);
  localparam logic [12:0] PAT [8] = '{
    13'b1010100000000, 13'b1110000000000, 13'b1010111000000, 13'b1010101110000,
    13'b1011101110000, 13'b1110101011100, 13'b1110101110111, 13'b1110111010100
  };
  localparam logic [3:0] LEN [8] = '{4'd5, 4'd3, 4'd7, 4'd9, 4'd9, 4'd11, 4'd13, 4'd11};
  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [12:0] r_shift;
  logic [3:0] r_bits_left;
  logic [GW-1:0] r_gap_left;
  logic [TW-1:0] r_tick_cnt;
  logic r_morse;
  logic w_loop, w_active, w_tick, w_ready, w_push, w_pop, w_repush, w_wr;
  logic [2:0] w_head, w_wr_data;
`ifdef MORSE_LOOP_EN
  assign w_loop = bus.loop;
`else
  assign w_loop = 1'b0;
`endif
  assign w_head = r_mem[r_rd_ptr];
  assign w_active = (r_state == SEND) || (r_state == GAP);
  assign w_tick = w_active && (r_tick_cnt == '0);
  assign w_ready = (r_count < DEPTH) && !bus.abort && !((r_state != IDLE) && w_loop);
  assign w_push = bus.sym_valid && w_ready;
  assign w_pop = (r_state == LOAD) && !bus.abort;
  assign w_repush = w_pop && w_loop;
  assign w_wr = w_push || w_repush;
  assign w_wr_data = w_repush ? w_head : bus.sym_in;
  assign bus.sym_ready = w_ready;
  assign bus.morse_out = r_morse;
  assign bus.busy = (r_state != IDLE);
  assign bus.unit_tick = w_tick;
  assign bus.fifo_count = r_count;
  // Next state: abort wins, then letter load, unit shifting and gap countdown
  always_comb begin
    w_next = bus.abort ? IDLE :
             (r_state == IDLE) ? ((bus.start && r_count != '0) ? LOAD : IDLE) :
             (r_state == LOAD) ? SEND :
             (r_state == SEND) ? ((w_tick && r_bits_left == 4'd1) ? GAP : SEND) :
             (w_tick && r_gap_left == GW'(1)) ? ((r_count != '0) ? LOAD : IDLE) : GAP;
  end
  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Letter storage; the looped re-push writes the popped head back to the tail
  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_wr_data;
  end
  // FIFO pointers and occupancy; abort flushes everything
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else if (bus.abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_wr) - CW'(w_pop);
    end
  end
  // Unit timer, pattern shifter and registered Morse line
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_shift <= '0;
      r_bits_left <= '0;
      r_gap_left <= '0;
      r_tick_cnt <= '0;
      r_morse <= 1'b0;
    end else if (bus.abort) begin
      r_tick_cnt <= TICK_MAX;
      r_morse <= 1'b0;
    end else if (r_state == LOAD) begin
      r_shift <= PAT[w_head];
      r_bits_left <= LEN[w_head];
      r_tick_cnt <= TICK_MAX;
      r_morse <= 1'b1;
    end else if (w_active) begin
      r_tick_cnt <= w_tick ? TICK_MAX : r_tick_cnt - 1'b1;
      if (w_tick && r_state == SEND && r_bits_left == 4'd1) begin
        r_morse <= 1'b0;
        r_gap_left <= GAP_INIT;
      end else if (w_tick && r_state == SEND) begin
        r_shift <= {r_shift[11:0], r_shift[12]};
        r_bits_left <= r_bits_left - 1'b1;
        r_morse <= r_shift[11];
      end
      if (w_tick && r_state == GAP) r_gap_left <= r_gap_left - 1'b1;
    end else begin
      r_tick_cnt <= TICK_MAX;
    end
  end
endmodule

// File: tb/tb_morse_msg_sequencer.sv
// tb_morse_msg_sequencer: vector table for the FIFO handshake, scoreboard for playback waveforms, hand sequences for abort/reset
module tb_morse_msg_sequencer;
  localparam int TD = 4;
  localparam int FD = 4;
  localparam int GU = 3;
  typedef struct {
    logic m;
    logic b;
    logic t;
    int c;
  } exp_t;
  typedef struct {
    logic [2:0] sym;
    logic valid;
    logic abort;
    logic ready;
    int cnt;
  } vec_t;
  logic clock = 1'b0;
  logic reset = 1'b0;
  int total = 0;
  int bad = 0;
  exp_t sb_q[$];
  logic [2:0] plan[$];
  string pats[8] = '{"10101", "111", "1010111", "101010111", "101110111", "11101010111", "1110101110111", "11101110101"};
  vec_t vt[9];
  morse_msg_sequencer_if #(.FIFO_DEPTH(FD)) bus();
  morse_msg_sequencer #(.TICK_DIV(TD), .FIFO_DEPTH(FD), .GAP_UNITS(GU)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t mk(input logic m, input logic b, input logic t, input int c);
    exp_t e;
    e.m = m;
    e.b = b;
    e.t = t;
    e.c = c;
    return e;
  endfunction
  // Expected per-cycle line state for the letters in plan, starting with the LOAD cycle
  task automatic expect_play(input bit track);
    int n;
    n = plan.size();
    for (int i = 0; i < n; i++) begin
      string p;
      p = pats[plan[i]];
      sb_q.push_back(mk(1'b0, 1'b1, 1'b0, track ? n - i : -1));
      for (int j = 0; j < p.len(); j++)
        for (int t = 0; t < TD; t++)
          sb_q.push_back(mk(p[j] == "1", 1'b1, t == TD - 1, track ? n - i - 1 : -1));
      for (int g = 0; g < GU * TD; g++)
        sb_q.push_back(mk(1'b0, 1'b1, (g % TD) == TD - 1, track ? n - i - 1 : -1));
    end
    sb_q.push_back(mk(1'b0, 1'b0, 1'b0, track ? 0 : -1));
  endtask
  always @(negedge clock) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_morse", bus.morse_out, e.m);
      chk("sb_busy", bus.busy, e.b);
      chk("sb_tick", bus.unit_tick, e.t);
      if (e.c >= 0) chk("sb_count", bus.fifo_count, e.c);
    end
  end
  task automatic push(input logic [2:0] s);
    @(negedge clock);
    bus.sym_in = s;
    bus.sym_valid = 1'b1;
    @(negedge clock);
    bus.sym_valid = 1'b0;
  endtask
  task automatic go(input bit track);
    @(negedge clock);
    bus.start = 1'b1;
    @(posedge clock);
    expect_play(track);
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  task automatic drain(input int budget);
    int k;
    k = 0;
    while (sb_q.size() > 0 && k < budget) begin
      @(negedge clock);
      k++;
    end
    if (sb_q.size() > 0) begin
      chk("drain_timeout", sb_q.size(), 0);
      sb_q.delete();
    end
    @(negedge clock);
  endtask
  task automatic pulse_start();
    @(negedge clock);
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end
  initial begin
    bus.sym_in = 3'd0;
    bus.sym_valid = 1'b0;
    bus.start = 1'b0;
    bus.abort = 1'b0;
`ifdef MORSE_LOOP_EN
    bus.loop = 1'b0;
`endif
    vt[0] = '{3'd0, 1'b1, 1'b0, 1'b1, 1};
    vt[1] = '{3'd1, 1'b1, 1'b0, 1'b1, 2};
    vt[2] = '{3'd2, 1'b1, 1'b0, 1'b1, 3};
    vt[3] = '{3'd3, 1'b1, 1'b0, 1'b1, 4};
    vt[4] = '{3'd4, 1'b1, 1'b0, 1'b0, 4};
    vt[5] = '{3'd4, 1'b0, 1'b1, 1'b0, 0};
    vt[6] = '{3'd6, 1'b1, 1'b1, 1'b0, 0};
    vt[7] = '{3'd5, 1'b1, 1'b0, 1'b1, 1};
    vt[8] = '{3'd5, 1'b0, 1'b1, 1'b0, 0};
    #12;
    chk("rst_morse", bus.morse_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_tick", bus.unit_tick, 0);
    chk("rst_count", bus.fifo_count, 0);
    chk("rst_ready", bus.sym_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      bus.sym_in = vt[i].sym;
      bus.sym_valid = vt[i].valid;
      bus.abort = vt[i].abort;
      #1;
      chk($sformatf("vec%0d_ready", i), bus.sym_ready, vt[i].ready);
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d_count", i), bus.fifo_count, vt[i].cnt);
    end
    @(negedge clock);
    bus.sym_valid = 1'b0;
    bus.abort = 1'b0;
    push(3'd0);
    plan.delete();
    plan.push_back(3'd0);
    go(1'b1);
    drain(200);
    push(3'd1);
    push(3'd6);
    push(3'd7);
    plan.delete();
    plan.push_back(3'd1);
    plan.push_back(3'd6);
    plan.push_back(3'd7);
    go(1'b1);
    drain(400);
    for (int i = 0; i < 4; i++) push(3'd1);
    chk("full_ready", bus.sym_ready, 0);
    plan.delete();
    for (int i = 0; i < 4; i++) plan.push_back(3'd1);
    plan.push_back(3'd0);
    go(1'b0);
    @(negedge clock);
    bus.sym_in = 3'd0;
    bus.sym_valid = 1'b1;
    #1;
    chk("play_push_ready", bus.sym_ready, 1);
    @(negedge clock);
    bus.sym_valid = 1'b0;
    drain(600);
    push(3'd3);
    push(3'd1);
    pulse_start();
    repeat (10) @(negedge clock);
    chk("v_unit3_morse", bus.morse_out, 1);
    chk("v_unit3_busy", bus.busy, 1);
    chk("v_unit3_count", bus.fifo_count, 1);
    bus.abort = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_morse", bus.morse_out, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.fifo_count, 0);
    @(negedge clock);
    bus.abort = 1'b0;
    pulse_start();
    repeat (3) @(negedge clock);
    chk("empty_start_busy", bus.busy, 0);
    chk("empty_start_morse", bus.morse_out, 0);
    push(3'd1);
    push(3'd2);
    pulse_start();
    repeat (16) @(negedge clock);
    chk("gap_busy", bus.busy, 1);
    chk("gap_morse", bus.morse_out, 0);
    chk("gap_count", bus.fifo_count, 1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_morse", bus.morse_out, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_tick", bus.unit_tick, 0);
    chk("arst_count", bus.fifo_count, 0);
    chk("arst_ready", bus.sym_ready, 1);
    @(negedge clock);
    reset = 1'b1;
    pulse_start();
    repeat (3) begin
      @(negedge clock);
      chk("post_rst_busy", bus.busy, 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/morse_msg_sequencer.md
# morse_msg_sequencer

Message-level controller for the Morse output path: buffers up to FIFO_DEPTH letter codes (S..Z, 3-bit), then, on a start pulse, plays them back-to-back on a single LED line. Each letter's unit-coded pattern is shifted out one Morse unit at a time, and a fixed inter-letter gap of zeros is inserted between letters. It replaces direct switch/key control of the single-letter shift register and rate divider. It sits between the switch/key inputs and LEDR[0].

## Interface
- TICK_DIV, 25000000: clock cycles per Morse unit (0.5 s at 50 MHz); must be ≥2.
- FIFO_DEPTH, 4: letter buffer depth; power of two, 2..16.
- GAP_UNITS, 3: zero units inserted after every letter; ≥1.
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low.
- sym_in  in  3  letter code: 0=S 1=T 2=U 3=V 4=W 5=X 6=Y 7=Z.
- sym_valid  in  1  push request for sym_in.
- sym_ready  out  1  FIFO can accept a push this cycle.
- start  in  1  one-cycle pulse; begins playback.
- abort  in  1  synchronous; flushes FIFO and stops playback.
- morse_out  out  1  registered Morse line (to LED).
- busy  out  1  high in any state other than IDLE.
- unit_tick  out  1  one-cycle strobe at each Morse unit boundary while busy.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  letters buffered.

## Operation
- Pattern ROM (MSB sent first, length in units): S 10101/5; T 111/3; U 1010111/7; V 101010111/9; W 101110111/9; X 11101010111/11; Y 1110101110111/13; Z 11101110101/11. Patterns are left-justified in a 13-bit shift register.
- FIFO: sym_ready = (fifo_count < FIFO_DEPTH) && !abort. A push occurs when sym_valid && sym_ready. Pushes are accepted in any state. A push and a pop in the same cycle leave the count unchanged.
- States: IDLE, LOAD, SEND, GAP.
- IDLE: if start && fifo_count>0 && !abort, go to LOAD. A start with an empty FIFO is ignored. A start in any other state is ignored.
- LOAD (1 cycle):
  - pop the FIFO head;
  - load its pattern into the shift register and its length into bits_left;
  - load the tick counter with TICK_DIV-1;
  - set morse_out to the pattern MSB (always 1);
  - go to SEND.
- SEND, on each unit tick:
  - if bits_left==1: morse_out<=0, gap_left<=GAP_UNITS, go to GAP;
  - otherwise: shift left, bits_left-1, morse_out<=next bit.
- GAP, on each unit tick:
  - gap_left decrements;
  - when gap_left==1 at a tick: go to LOAD if fifo_count>0, otherwise go to IDLE.
  - morse_out stays 0.
  - Letters pushed during playback are therefore played in the same message.
- Tick counter:
  - counts down from TICK_DIV-1 while in SEND or GAP;
  - unit_tick=1 in the cycle where the count is 0, then the counter reloads TICK_DIV-1;
  - it is held at TICK_DIV-1 in IDLE and LOAD.
- abort (any state, highest priority): next edge gives state IDLE, FIFO emptied (count 0), morse_out 0, no push accepted that cycle.

## Timing
- Reset values: state IDLE; morse_out 0; busy 0; unit_tick 0; fifo_count 0; sym_ready 1; all counters cleared.
- start sampled high at edge k: LOAD after edge k, morse_out=1 after edge k+1.
- Each pattern unit holds exactly TICK_DIV cycles. The gap lasts GAP_UNITS*TICK_DIV cycles, then LOAD takes 1 cycle.
- Letter period = (len+GAP_UNITS)*TICK_DIV + 1 cycles.
- busy falls on the edge that ends the last gap. morse_out returns to 0 one edge after the last SEND unit ends.
- fifo_count updates on the edge after a push or pop.
- sym_ready is combinational from the registered count and abort.
- reset mid-operation: all outputs return to their reset values immediately (asynchronous).

## Configuration
- MORSE_LOOP_EN defined:
  - adds input port loop (1 bit).
  - In LOAD with loop=1, the popped code is re-pushed at the FIFO tail in the same cycle, so the message repeats until abort or loop=0.
  - sym_ready is forced 0 while busy && loop.
- MORSE_LOOP_EN undefined: no loop port; each letter plays once.

## Test plan
- TICK_DIV=4, GAP_UNITS=3: push S, pulse start → morse_out sequence 1,0,1,0,1 at 4 cycles/unit, then 12 cycles of 0, busy low 33 cycles after start.
- Push T, Y, Z, then start → units 111,000,1110101110111,000,11101110101,000 back-to-back; fifo_count steps 3→2→1→0 at each LOAD.
- Push 4 letters (depth 4) → sym_ready=0; a 5th sym_valid is not counted; a push during SEND after the first pop is accepted and played.
- Assert abort during the third unit of V → next edge: morse_out=0, busy=0, fifo_count=0; a later start with an empty FIFO is ignored.
- Assert reset low mid-GAP → all outputs at reset values without a clock edge. start with an empty FIFO → busy stays 0.
- With MORSE_LOOP_EN, push U, loop=1, start → U repeats; fifo_count stays 1. Drop loop → playback ends after the current letter and gap.
